// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer helpers for the dual-clock FIFO pointer stages
package fifo_pkg;
  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction
  // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
    return b;
  endfunction
  // Gray pointer that would mean "full" relative to a remote pointer: two MSBs inverted.
  function automatic logic [31:0] full_ref(input logic [31:0] g, input int pw);
    return g ^ (32'd3 << (pw - 2));
  endfunction
endpackage

// File: rtl/bin2gray.sv
// bin2gray: combinational binary to reflected Gray code converter
module bin2gray #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);
  assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

// File: rtl/gray_sync.sv
// gray_sync: multi-stage flop chain bringing a Gray pointer into the local clock domain
module gray_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             srstn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] rq_q [STAGES];
  // Shift the remote pointer through the chain; stage 0 samples the raw input directly.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      for (int i = 0; i < STAGES; i++) rq_q[i] <= '0;
    end else begin
      rq_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) rq_q[i] <= rq_q[i-1];
    end
  end
  assign q_o = rq_q[STAGES-1];
endmodule

// File: rtl/fifo_wr_ptr_gray.sv
// fifo_wr_ptr_gray: write-side pointer, Gray export, full flag, fill level and overflow pulse
module fifo_wr_ptr_gray
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  localparam int PW = ptr_width(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  wr_accept,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [PW-1:0]         wr_ptr_gray,
  input  logic [PW-1:0]         rd_ptr_gray_async,
  output logic [PW-1:0]         level,
  output logic                  wr_overflow
);
  logic [PW-1:0] wr_ptr_bin_q, bin_next, gray_next, gray_q, level_q, level_d, rq_s;
  logic          full_q, full_d, ovf_q;
  assign wr_accept = wr_en & ~full_q;
  assign bin_next  = wr_ptr_bin_q + PW'(wr_accept);
  bin2gray #(.WIDTH(PW)) u_b2g (
    .bin_i  (bin_next),
    .gray_o (gray_next)
  );
  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .srstn (srstn),
    .d_i   (rd_ptr_gray_async),
    .q_o   (rq_s)
  );
  // Full and level are judged against the pointer as it will be after this edge.
  always_comb begin
    full_d  = (32'(gray_next) == full_ref(32'(rq_s), PW));
    level_d = PW'(32'(bin_next) - gray2bin(32'(rq_s)));
  end
  // Pointer, exported Gray pointer and status flags all update on the accepting edge.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      wr_ptr_bin_q <= '0;
      gray_q       <= '0;
      full_q       <= 1'b0;
      level_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      wr_ptr_bin_q <= bin_next;
      gray_q       <= gray_next;
      full_q       <= full_d;
      level_q      <= level_d;
      ovf_q        <= wr_en & full_q;
    end
  end
  assign full        = full_q;
  assign wr_addr     = wr_ptr_bin_q[ADDR_WIDTH-1:0];
  assign wr_ptr_gray = gray_q;
  assign level       = level_q;
  assign wr_overflow = ovf_q;
endmodule

// File: doc/fifo_wr_ptr_gray.md
Name: fifo_wr_ptr_gray

Overview:
Write-side pointer stage of the dual-clock FIFO, sitting directly upstream of the bin2gray converter.
- Holds the binary write pointer and advances it on accepted writes.
- Feeds the next binary pointer to bin2gray and registers the Gray result for clock-domain crossing.
- Synchronises the remote read-side Gray pointer and produces a registered full flag, fill level and overflow pulse.

Parameters:
ADDR_WIDTH, 4, FIFO address width; depth = 2**ADDR_WIDTH; pointer width PW = ADDR_WIDTH+1
SYNC_STAGES, 2, flip-flop stages in the remote pointer synchroniser; legal values >= 2

Ports:
clk  input  1  write-domain clock
srstn  input  1  synchronous active-low reset
wr_en  input  1  write request
full  output  1  registered full flag; write requests are rejected while high
wr_accept  output  1  combinational wr_en & ~full; memory write strobe
wr_addr  output  ADDR_WIDTH  memory write address = wr_ptr_bin[ADDR_WIDTH-1:0]
wr_ptr_gray  output  PW  registered Gray write pointer, sent to the read domain
rd_ptr_gray_async  input  PW  read-domain Gray pointer, asynchronous to clk
level  output  PW  registered fill level, 0..2**ADDR_WIDTH
wr_overflow  output  1  registered one-cycle pulse when wr_en is seen while full

Behaviour:
- Clocking: one clock, clk. Reset is srstn: synchronous, active-low, sampled on the rising edge of clk.
- Reset values: the following are all 0 on the first rising edge with srstn low, regardless of wr_en:
  - internal wr_ptr_bin;
  - wr_ptr_gray, full, level, wr_overflow;
  - every synchroniser stage.
  - wr_addr = 0 as a consequence.
- Reset mid-operation: reset discards all state on the same edge. There is no drain.
- Accept: wr_accept = wr_en & ~full.
  - bin_next = wr_ptr_bin + wr_accept, computed modulo 2**PW.
  - 2**PW-1 wraps to 0.
- Gray: gray_next = bin2gray(bin_next); wr_ptr_gray <= gray_next.
  - wr_ptr_gray comes straight from a flop, with no combinational logic after it, so the crossing is glitch-free.
  - Consecutive values differ in exactly 1 bit, including at the wrap point 1<<(PW-1) -> 0.
- Latency: wr_addr and wr_ptr_gray show the new value on the edge that accepts a write. A memory write at address A and the pointer advance past A happen on the same edge.
- Synchroniser:
  - rq[0] <= rd_ptr_gray_async; rq[i] <= rq[i-1] for i >= 1.
  - rq_s = rq[SYNC_STAGES-1].
  - No logic may sit between rd_ptr_gray_async and rq[0].
- Full:
  - full <= (gray_next == {~rq_s[PW-1:PW-2], rq_s[PW-3:0]}).
  - For ADDR_WIDTH=1 the comparison uses only the inverted two MSBs.
  - Full asserts on the edge that accepts the write bringing the level to depth.
  - Full deasserts SYNC_STAGES+1 edges after a remote pointer change is stable at the input.
- Level:
  - level <= bin_next - gray2bin(rq_s), computed modulo 2**PW.
  - gray2bin is a prefix XOR from MSB to LSB.
  - Level is pessimistic: it lags remote reads by SYNC_STAGES+1 cycles and is never below the true count.
- Overflow: wr_overflow <= wr_en & full. The pointer does not move on such a cycle.
- Simultaneous events:
  - If a remote read arrives while full=1 and wr_en=1 is asserted, the write is rejected that cycle.
  - The write is accepted on the first cycle after full deasserts, provided wr_en is still high.
- Operating assumption: the remote pointer never advances past wr_ptr_gray. Behaviour is undefined if this is violated, and the block does not check it.

Decomposition:
- Shared package fifo_pkg:
  - localparam function ptr_width(addr_w) = addr_w+1;
  - function gray2bin;
  - full-compare helper (invert the two MSBs).
- Sub-modules:
  - Instantiate the existing bin2gray (WIDTH=PW) on bin_next.
  - gray_sync (PW-wide, SYNC_STAGES-deep flop chain) is the one natural new sub-module. The read-side pointer stage reuses it.

Test Plan:
1. Reset. srstn=0 for 3 cycles with wr_en=1 and rd_ptr_gray_async=5'b10101.
   Required: wr_ptr_gray=0, wr_addr=0, full=0, level=0, wr_overflow=0, and no increment.
2. Fill. rd_ptr_gray_async=0; wr_en=1 for 16 cycles.
   - wr_addr steps 0..15.
   - wr_ptr_gray steps 00001, 00011, 00010, ... and ends at 11000.
   - full=1 and level=16 on the 16th accepting edge.
   - A 17th wr_en gives wr_overflow=1 for exactly 1 cycle, and wr_ptr_gray stays 11000.
3. Release. From full, drive rd_ptr_gray_async=00110 (bin 4).
   - full stays 1 for the first 2 edges.
   - On the 3rd edge: full=0 and level=12.
   - Next wr_en is accepted with wr_addr=0.
4. Wrap. 40 writes with the remote pointer tracking the write pointer minus 3.
   - wr_ptr_gray passes 10000 -> 00000.
   - A checker confirms every wr_ptr_gray change flips exactly 1 bit.
   - level stays within 3..3+SYNC_STAGES+1 and full never asserts.
5. Mid-op reset. At level=7, srstn=0 for one cycle.
   Required: on the next edge all outputs and synchroniser stages are 0. After release with rd_ptr_gray_async=0, the first write gives wr_addr=0.
6. Simultaneous. full=1, wr_en held 1, remote pointer freed at edge N.
   - Writes are rejected (wr_overflow=1) through edge N+2.
   - Exactly one write is accepted on edge N+3.
   - full re-asserts on that same edge.
